pixel_plot_sink: RTL and testbench

//  Receiving end of the pixel-plot interface driven by the screen drawers (clear, sprite, path).

---
 rtl/pixel_plot_sink_pkg.sv | 25 ++
 rtl/pixel_plot_sink_if.sv | 23 ++
 rtl/pixel_plot_sink_fifo.sv | 49 ++++
 rtl/pixel_plot_sink.sv | 80 ++++++++
 tb/tb_pixel_plot_sink.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pixel_plot_sink_pkg.sv
// Shared screen geometry, pixel record and output-stage state for the pixel-plot sink.
package pixel_plot_sink_pkg;
  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int FB_ADDR_W = 17;
  localparam int COLOR_W   = 3;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  typedef enum logic {EMPTY_OUT, WRITE} out_state_t;

  // Y*320 + X built from two shifts so no multiplier is inferred.
  function automatic logic [FB_ADDR_W-1:0] fb_linear_addr(input logic [X_W-1:0] x,
                                                          input logic [Y_W-1:0] y);
    logic [FB_ADDR_W-1:0] yy;
    yy = {{(FB_ADDR_W-Y_W){1'b0}}, y};
    return (yy << 8) + (yy << 6) + {{(FB_ADDR_W-X_W){1'b0}}, x};
  endfunction
endpackage

// File: rtl/pixel_plot_sink_if.sv
// Plot request bus (drawers -> sink) and framebuffer write port (sink -> framebuffer).
interface pixel_plot_if;
  import pixel_plot_sink_pkg::*;
  logic               plot;
  logic [X_W-1:0]     X;
  logic [Y_W-1:0]     Y;
  logic [COLOR_W-1:0] color;
  logic               ready;

  modport master (output plot, X, Y, color, input ready);
  modport slave  (input plot, X, Y, color, output ready);
endinterface

interface pixel_fb_if;
  import pixel_plot_sink_pkg::*;
  logic                 fb_we;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [COLOR_W-1:0]   fb_data;
  logic                 fb_busy;

  modport master (output fb_we, fb_addr, fb_data, input fb_busy);
  modport slave  (input fb_we, fb_addr, fb_data, output fb_busy);
endinterface

// File: rtl/pixel_plot_sink_fifo.sv
// Small circular FIFO of range-checked pixels; push ignored when full, pop ignored when empty.
module pixel_fifo
  import pixel_plot_sink_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  pixel_t        din,
  input  logic          pop,
  output pixel_t        dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  pixel_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/pixel_plot_sink.sv
// Pixel-plot sink: range check + drop counter, FIFO, address adder, 2-state framebuffer writer.
module pixel_plot_sink #(
  parameter int DEPTH    = 4,
  parameter int SCREEN_W = pixel_plot_sink_pkg::SCREEN_W,
  parameter int SCREEN_H = pixel_plot_sink_pkg::SCREEN_H
) (
  input  logic        clock,
  input  logic        resetn,
  pixel_plot_if.slave pin,
  pixel_fb_if.master  fb,
  output logic        idle,
  output logic [7:0]  drop_count
);
  import pixel_plot_sink_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H);

  pixel_t        in_px, head;
  logic          full, empty, accept, in_range, push, drop, pop;
  logic [CW-1:0] count;
  out_state_t    state;

  assign in_px    = '{x: pin.X, y: pin.Y, color: pin.color};
  assign in_range = (pin.X < X_LIM) && (pin.Y < Y_LIM);
  // ready comes straight from the registered count, never from plot.
  assign pin.ready = ~full;
  assign accept   = pin.plot & ~full;
  assign push     = accept & in_range;
  assign drop     = accept & ~in_range;
  assign pop      = ~empty & ((state == EMPTY_OUT) | ~fb.fb_busy);
  assign idle     = (count == '0) && (state == EMPTY_OUT);

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .resetn(resetn),
    .push  (push),
    .din   (in_px),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                         drop_count <= '0;
    else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= EMPTY_OUT;
      fb.fb_we   <= 1'b0;
      fb.fb_addr <= '0;
      fb.fb_data <= '0;
    end else begin
      case (state)
        EMPTY_OUT: if (!empty) begin
          fb.fb_we   <= 1'b1;
          fb.fb_addr <= fb_linear_addr(head.x, head.y);
          fb.fb_data <= head.color;
          state      <= WRITE;
        end
        // Busy holds everything; otherwise the current write retires and the next one loads.
        WRITE: if (!fb.fb_busy) begin
          if (!empty) begin
            fb.fb_addr <= fb_linear_addr(head.x, head.y);
            fb.fb_data <= head.color;
          end else begin
            fb.fb_we <= 1'b0;
            state    <= EMPTY_OUT;
          end
        end
        default: state <= EMPTY_OUT;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: hand-computed addresses, drops, stalls and reset.
module tb_pixel_plot_sink;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       idle;
  logic [7:0] drop_count;

  pixel_plot_if pif();
  pixel_fb_if   fif();

  pixel_plot_sink #(.DEPTH(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .pin       (pif),
    .fb        (fif),
    .idle      (idle),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rlow = 0;
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];

  // A write retires on the next posedge when fb_we is high and fb_busy is low.
  always @(negedge clock) begin
    cyc++;
    if (resetn && fif.fb_we && !fif.fb_busy) begin
      wq_addr.push_back(int'(fif.fb_addr));
      wq_data.push_back(int'(fif.fb_data));
      wq_cyc.push_back(cyc);
    end
    if (!pif.ready) rlow++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  // Presents a plot and returns after the edge on which it was accepted; plot left high.
  task automatic send(input int x, input int y, input int c);
    int  n;
    logic r;
    n = 0;
    pif.plot  = 1'b1;
    pif.X     = x[8:0];
    pif.Y     = y[7:0];
    pif.color = c[2:0];
    do begin
      r = pif.ready;
      step();
      n++;
    end while (!r && n < 100);
    if (!r) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    pif.plot = 1'b0;
    while (!(idle && !fif.fb_we) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int acc, idx;
    logic r;
    pif.plot = 1'b0; pif.X = '0; pif.Y = '0; pif.color = '0;
    fif.fb_busy = 1'b0;
    step();
    chk("rst_ready", int'(pif.ready), 1);
    chk("rst_we",    int'(fif.fb_we), 0);
    chk("rst_addr",  int'(fif.fb_addr), 0);
    chk("rst_data",  int'(fif.fb_data), 0);
    chk("rst_idle",  int'(idle), 1);
    chk("rst_drop",  int'(drop_count), 0);
    resetn = 1'b1;
    step();

    // 1: single plot, latency and idle
    clear_q();
    send(5, 2, 5);
    pif.plot = 1'b0;
    chk("t1_idle_lo", int'(idle), 0);
    chk("t1_we_lo",   int'(fif.fb_we), 0);
    step();
    chk("t1_we",   int'(fif.fb_we), 1);
    chk("t1_addr", int'(fif.fb_addr), 645);
    chk("t1_data", int'(fif.fb_data), 5);
    step();
    chk("t1_we_off", int'(fif.fb_we), 0);
    chk("t1_idle",   int'(idle), 1);
    chk("t1_nwr",    wq_addr.size(), 1);

    // 2: burst of 10, sustained one per cycle
    clear_q();
    rlow = 0;
    for (int i = 0; i < 10; i++) send(7 * i, i, i % 8);
    wait_idle();
    chk("t2_nwr", wq_addr.size(), 10);
    for (int i = 0; i < 10 && i < wq_addr.size(); i++) begin
      chk($sformatf("t2_addr%0d", i), wq_addr[i], i * 320 + 7 * i);
      chk($sformatf("t2_data%0d", i), wq_data[i], i % 8);
    end
    if (wq_cyc.size() == 10) chk("t2_b2b", wq_cyc[9] - wq_cyc[0], 9);
    chk("t2_rlow", rlow, 0);

    // 3: stall for 20 cycles
    clear_q();
    fif.fb_busy = 1'b1;
    acc = 0; idx = 0;
    for (int k = 0; k < 20; k++) begin
      pif.plot = 1'b1; pif.X = 9'(10 + idx); pif.Y = 8'd100; pif.color = 3'(idx);
      r = pif.ready;
      step();
      if (r) begin acc++; idx++; end
    end
    pif.plot = 1'b0;
    chk("t3_acc",   acc, 5);
    chk("t3_ready", int'(pif.ready), 0);
    chk("t3_we",    int'(fif.fb_we), 1);
    chk("t3_addr",  int'(fif.fb_addr), 32010);
    chk("t3_data",  int'(fif.fb_data), 0);
    chk("t3_nwr0",  wq_addr.size(), 0);
    fif.fb_busy = 1'b0;
    wait_idle();
    chk("t3_nwr", wq_addr.size(), 5);
    for (int i = 0; i < 5 && i < wq_addr.size(); i++)
      chk($sformatf("t3_addr%0d", i), wq_addr[i], 32010 + i);

    // 4: range boundaries
    clear_q();
    send(320, 0, 1);
    send(0, 240, 1);
    send(319, 239, 2);
    wait_idle();
    chk("t4_drop", int'(drop_count), 2);
    chk("t4_nwr",  wq_addr.size(), 1);
    if (wq_addr.size() > 0) begin
      chk("t4_addr", wq_addr[0], 76799);
      chk("t4_data", wq_data[0], 2);
    end

    // 5: drop counter saturation
    clear_q();
    for (int i = 0; i < 300; i++) send(400, 0, 7);
    wait_idle();
    chk("t5_drop", int'(drop_count), 255);
    chk("t5_nwr",  wq_addr.size(), 0);
    chk("t5_idle", int'(idle), 1);

    // 6: reset with one write held and 3 buffered
    clear_q();
    fif.fb_busy = 1'b1;
    for (int i = 0; i < 4; i++) send(i, 1, 3);
    pif.plot = 1'b0;
    chk("t6_we_pre", int'(fif.fb_we), 1);
    resetn = 1'b0;
    #1;
    chk("t6_we",    int'(fif.fb_we), 0);
    chk("t6_addr",  int'(fif.fb_addr), 0);
    chk("t6_data",  int'(fif.fb_data), 0);
    chk("t6_ready", int'(pif.ready), 1);
    chk("t6_idle",  int'(idle), 1);
    chk("t6_drop",  int'(drop_count), 0);
    step();
    step();
    resetn = 1'b1;
    fif.fb_busy = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t6_nwr",  wq_addr.size(), 0);
    chk("t6_idle2", int'(idle), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
